// File: rtl/eth_udp_rx.sv
// eth_udp_rx: GMII UDP receiver. Strips preamble, filters MAC/IPv4/UDP and streams the payload over AXI4-Stream.
// Optional FCS check is enabled by defining ETH_UDP_RX_FCS_CHECK_EN.
module eth_udp_rx #(
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter bit          CHECK_MAC    = 1'b1,
  parameter int unsigned MIN_UDP_LEN  = 9
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  input  logic [15:0] local_port,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [15:0] payload_len,
  output logic        frame_done,
  output logic        frame_good
);
  typedef enum logic [2:0] {
    S_WAIT_IDLE, S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_TAIL, S_DONE, S_DROP
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_hdr_cnt;
  logic [15:0] r_rem;
  logic [7:0]  r_len_hi;
  logic        r_ucast_ok, r_bcast_ok, r_bad, r_first;
  logic [7:0]  w_mac_byte, w_ip_byte;
  logic [15:0] w_len;
  logic        w_ucast_hit, w_bcast_hit, w_mac_ok, w_field_ok, w_sfd, w_in_frame, w_fcs_ok;

  // Expected MAC byte for header bytes 0..5 and IP byte for header bytes 30..33.
  assign w_mac_byte  = 8'(local_mac >> {3'd5 - r_hdr_cnt[2:0], 3'b000});
  assign w_ip_byte   = 8'(local_ip >> {2'd1 - r_hdr_cnt[1:0], 3'b000});
  assign w_len       = {r_len_hi, rxd};
  assign w_ucast_hit = r_ucast_ok && rxd == w_mac_byte;
  assign w_bcast_hit = r_bcast_ok && rxd == 8'hFF;
  assign w_mac_ok    = !CHECK_MAC || w_ucast_hit || (ACCEPT_BCAST && w_bcast_hit);
  assign w_sfd       = r_state == S_PREAMBLE && rx_dv && rxd == 8'hD5;
  assign w_in_frame  = rx_dv && (r_state == S_HEADER || r_state == S_PAYLOAD || r_state == S_TAIL);

  // Per-byte header filter; the MAC verdict is taken once all six bytes are in.
  always_comb begin
    w_field_ok = 1'b1;
    case (r_hdr_cnt)
      6'd5:                      w_field_ok = w_mac_ok;
      6'd12:                     w_field_ok = rxd == 8'h08;
      6'd13:                     w_field_ok = rxd == 8'h00;
      6'd14:                     w_field_ok = rxd == 8'h45;
      6'd23:                     w_field_ok = rxd == 8'h11;
      6'd30, 6'd31, 6'd32, 6'd33: w_field_ok = rxd == w_ip_byte;
      6'd36:                     w_field_ok = rxd == local_port[15:8];
      6'd37:                     w_field_ok = rxd == local_port[7:0];
      6'd39:                     w_field_ok = w_len >= 16'(MIN_UDP_LEN);
      default:                   w_field_ok = 1'b1;
    endcase
  end

  // Next-state logic; DONE handles a new frame start exactly like IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_IDLE:    w_state_nxt = rx_dv ? S_WAIT_IDLE : S_IDLE;
      S_IDLE, S_DONE: w_state_nxt = !rx_dv ? S_IDLE : rxd == 8'h55 ? S_PREAMBLE : S_DROP;
      S_PREAMBLE:     w_state_nxt = !rx_dv ? S_IDLE : rxd == 8'hD5 ? S_HEADER : rxd == 8'h55 ? S_PREAMBLE : S_DROP;
      S_HEADER:       w_state_nxt = !rx_dv ? S_IDLE : !w_field_ok ? S_DROP : r_hdr_cnt == 6'd41 ? S_PAYLOAD : S_HEADER;
      S_PAYLOAD:      w_state_nxt = !rx_dv ? S_DONE : r_rem == 16'd1 ? S_TAIL : S_PAYLOAD;
      S_TAIL:         w_state_nxt = rx_dv ? S_TAIL : S_DONE;
      S_DROP:         w_state_nxt = rx_dv ? S_DROP : S_IDLE;
      default:        w_state_nxt = S_WAIT_IDLE;
    endcase
  end

  // State register; reset waits for the line to go idle before hunting for a preamble.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_WAIT_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Header counters, length capture, error tracking and one-cycle-latency payload output.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_hdr_cnt     <= '0;
      r_rem         <= '0;
      r_len_hi      <= '0;
      r_ucast_ok    <= 1'b0;
      r_bcast_ok    <= 1'b0;
      r_bad         <= 1'b0;
      r_first       <= 1'b0;
      payload_len   <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      if (w_sfd) begin
        r_hdr_cnt  <= '0;
        r_bad      <= rx_er;
        r_ucast_ok <= 1'b1;
        r_bcast_ok <= 1'b1;
        r_first    <= 1'b1;
      end
      if (w_in_frame && rx_er) r_bad <= 1'b1;
      if (r_state == S_HEADER && rx_dv) begin
        r_hdr_cnt <= r_hdr_cnt + 6'd1;
        if (r_hdr_cnt < 6'd6) begin
          r_ucast_ok <= w_ucast_hit;
          r_bcast_ok <= w_bcast_hit;
        end
        if (r_hdr_cnt == 6'd38) r_len_hi <= rxd;
        if (r_hdr_cnt == 6'd39 && w_field_ok) begin
          payload_len <= w_len - 16'd8;
          r_rem       <= w_len - 16'd8;
        end
      end
      if (r_state == S_PAYLOAD && rx_dv) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= rxd;
        m_axis_tuser  <= r_first;
        m_axis_tlast  <= r_rem == 16'd1;
        r_first       <= 1'b0;
        r_rem         <= r_rem - 16'd1;
      end
      if (r_state == S_PAYLOAD && !rx_dv) r_bad <= 1'b1;
    end
  end

`ifdef ETH_UDP_RX_FCS_CHECK_EN
  logic [31:0] r_crc, w_crc_nxt;

  // Reflected CRC-32 step over one byte, LSB first.
  always_comb begin
    w_crc_nxt = r_crc ^ {24'h0, rxd};
    for (int i = 0; i < 8; i++) w_crc_nxt = w_crc_nxt[0] ? (w_crc_nxt >> 1) ^ 32'hEDB88320 : w_crc_nxt >> 1;
  end

  // CRC runs from the first byte after SFD through the FCS.
  always_ff @(posedge clk) begin
    if (!resetn || w_sfd) r_crc <= '1;
    else if (w_in_frame)  r_crc <= w_crc_nxt;
  end

  // The shift-right register holds the residue 0xC704DD7B bit-reversed.
  assign w_fcs_ok = r_crc == 32'hDEBB20E3;
`else
  assign w_fcs_ok = 1'b1;
`endif

  assign frame_done = r_state == S_DONE;
  assign frame_good = frame_done && !r_bad && w_fcs_ok;
endmodule

// File: tb/tb_eth_udp_rx.sv
// tb_eth_udp_rx: randomized frames against a field-level reference model of eth_udp_rx.
module tb_eth_udp_rx;
  localparam logic [47:0] LMAC  = 48'h085700F4AEE5;
  localparam logic [31:0] LIP   = 32'hC0A8C865;
  localparam logic [15:0] LPORT = 16'd1536;
`ifdef ETH_UDP_RX_FCS_CHECK_EN
  localparam bit FCS_EN = 1'b1;
`else
  localparam bit FCS_EN = 1'b0;
`endif

  logic clk = 1'b0, resetn = 1'b0, rx_dv = 1'b0, rx_er = 1'b0;
  logic [7:0] rxd = 8'h00;
  logic [7:0] a_tdata, b_tdata;
  logic a_tvalid, a_tlast, a_tuser, a_done, a_good;
  logic b_tvalid, b_tlast, b_tuser, b_done, b_good;
  logic [15:0] a_len, b_len;

  eth_udp_rx dut_a (
    .clk(clk), .resetn(resetn), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .local_mac(LMAC), .local_ip(LIP), .local_port(LPORT),
    .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tlast(a_tlast), .m_axis_tuser(a_tuser),
    .payload_len(a_len), .frame_done(a_done), .frame_good(a_good));

  eth_udp_rx #(.ACCEPT_BCAST(1'b0)) dut_b (
    .clk(clk), .resetn(resetn), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .local_mac(LMAC), .local_ip(LIP), .local_port(LPORT),
    .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser),
    .payload_len(b_len), .frame_done(b_done), .frame_good(b_good));

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  logic [9:0] obs_q[$], exp_q[$];
  int obs_cyc[$];
  bit done_q[$], exp_good_q[$];
  int b_beats, b_dones, exp_b_beats, exp_b_dones, first_cyc;
  logic [15:0] exp_len;

  always @(negedge clk) begin
    if (a_tvalid) begin
      obs_q.push_back({a_tuser, a_tlast, a_tdata});
      obs_cyc.push_back(cyc);
    end
    if (a_done) done_q.push_back(a_good);
    if (b_tvalid) b_beats = b_beats + 1;
    if (b_done) b_dones = b_dones + 1;
  end

  task automatic drive(input logic dv, input logic [7:0] d, input logic er, input logic rn);
    @(posedge clk);
    #1;
    rx_dv = dv; rxd = d; rx_er = er; resetn = rn;
  endtask

  task automatic settle();
    repeat (6) drive(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic clear_obs();
    obs_q.delete(); exp_q.delete(); obs_cyc.delete(); done_q.delete(); exp_good_q.delete();
    b_beats = 0; b_dones = 0; exp_b_beats = 0; exp_b_dones = 0; first_cyc = -1;
  endtask

  // Builds a frame from fields, drives it, and appends the model's expectations.
  task automatic send_frame(input logic [47:0] dmac, input logic [15:0] etype, input logic [7:0] vihl,
                            input logic [7:0] proto, input logic [31:0] dip, input logic [15:0] dport,
                            input logic [15:0] ulen, input bit seqpay, input int trunc, input int er_pay,
                            input int rst_pay, input bit flip, input int gap);
    logic [7:0] f[$], pay[$];
    logic [31:0] c;
    logic [15:0] tot;
    int npay, pad, nsend, sent, got;
    bit hdr_ok, acc_a, acc_b;
    npay = int'(ulen) - 8;
    if (npay < 0) npay = 0;
    tot = ulen + 16'd20;
    for (int i = 5; i >= 0; i--) f.push_back(dmac[8*i +: 8]);
    repeat (6) f.push_back(8'($urandom));
    f.push_back(etype[15:8]); f.push_back(etype[7:0]); f.push_back(vihl); f.push_back(8'h00);
    f.push_back(tot[15:8]); f.push_back(tot[7:0]);
    repeat (4) f.push_back(8'($urandom));
    f.push_back(8'h40); f.push_back(proto);
    repeat (6) f.push_back(8'($urandom));
    for (int i = 3; i >= 0; i--) f.push_back(dip[8*i +: 8]);
    repeat (2) f.push_back(8'($urandom));
    f.push_back(dport[15:8]); f.push_back(dport[7:0]); f.push_back(ulen[15:8]); f.push_back(ulen[7:0]);
    f.push_back(8'h00); f.push_back(8'h00);
    for (int i = 0; i < npay; i++) begin
      pay.push_back(seqpay ? 8'(i) : 8'($urandom));
      f.push_back(pay[i]);
    end
    pad = 46 - (int'(ulen) + 20);
    if (pad > 0) repeat (pad) f.push_back(8'h00);
    c = '1;
    foreach (f[i]) begin
      c = c ^ {24'h0, f[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    c = ~c;
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
    if (flip) f[f.size()-2] = f[f.size()-2] ^ 8'h10;
    nsend = trunc >= 0 ? 42 + trunc : f.size();
    repeat (7) drive(1'b1, 8'h55, 1'b0, 1'b1);
    drive(1'b1, 8'hD5, 1'b0, 1'b1);
    for (int i = 0; i < nsend; i++) begin
      drive(1'b1, f[i], er_pay >= 0 && i == 42 + er_pay,
            !(rst_pay >= 0 && (i == 42 + rst_pay || i == 43 + rst_pay)));
      if (i == 42 && first_cyc < 0) first_cyc = cyc;
    end
    repeat (gap) drive(1'b0, 8'h00, 1'b0, 1'b1);
    hdr_ok = etype == 16'h0800 && vihl == 8'h45 && proto == 8'h11 && dip == LIP && dport == LPORT && ulen >= 16'd9;
    acc_a  = hdr_ok && (dmac == LMAC || dmac == '1);
    acc_b  = hdr_ok && dmac == LMAC;
    sent   = trunc >= 0 ? trunc : npay;
    got    = rst_pay >= 0 ? rst_pay : sent;
    if (acc_a) begin
      for (int i = 0; i < got; i++) exp_q.push_back({i == 0, i == npay - 1, pay[i]});
      if (rst_pay < 0) exp_good_q.push_back(sent == npay && er_pay < 0 && !(flip && FCS_EN));
      exp_len = rst_pay >= 0 ? 16'd0 : 16'(npay);
    end else if (rst_pay >= 0) exp_len = 16'd0;
    if (acc_b) begin
      exp_b_beats += got;
      if (rst_pay < 0) exp_b_dones++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if ({a_tvalid, a_tlast, a_tuser, a_done, a_good} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {a_tvalid, a_tlast, a_tuser, a_done, a_good});
    end
    checks++;
    if (a_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata: got %h want 00", a_tdata); end
    checks++;
    if (a_len !== 16'h0000) begin errors++; $display("FAIL reset_len: got %h want 0000", a_len); end
    exp_len = 16'd0;
    repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_nominal();
    clear_obs();
    send_frame(LMAC, 16'h0800, 8'h45, 8'h11, LIP, LPORT, 16'd16, 1'b1, -1, -1, -1, 1'b0, 12);
    settle();
    checks++;
    if (obs_q.size() !== 8) begin errors++; $display("FAIL nominal_beats: got %0d want 8", obs_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL nominal_beat%0d: got %h want %h", i, i < obs_q.size() ? obs_q[i] : 10'h3FF, exp_q[i]);
      end
    end
    checks++;
    if (obs_cyc.size() == 0 || obs_cyc[0] !== first_cyc + 1) begin
      errors++; $display("FAIL nominal_latency: got %0d want %0d", obs_cyc.size() > 0 ? obs_cyc[0] : -1, first_cyc + 1);
    end
    checks++;
    if (done_q.size() !== 1 || done_q[0] !== 1'b1) begin
      errors++; $display("FAIL nominal_done: got %0d pulses want 1 good", done_q.size());
    end
    checks++;
    if (a_len !== 16'd8) begin errors++; $display("FAIL nominal_len: got %0d want 8", a_len); end
    checks++;
    if (b_beats !== exp_b_beats || b_dones !== exp_b_dones) begin
      errors++; $display("FAIL nominal_dutb: got %0d/%0d want %0d/%0d", b_beats, b_dones, exp_b_beats, exp_b_dones);
    end
  endtask

  task automatic test_filter();
    for (int k = 0; k < 4; k++) begin
      clear_obs();
      send_frame(k == 0 ? 48'h085700F4AEE6 : LMAC, 16'h0800, 8'h45, k == 2 ? 8'h06 : 8'h11, LIP,
                 k == 1 ? 16'd1537 : LPORT, k == 3 ? 16'd8 : 16'd16, 1'b1, -1, -1, -1, 1'b0, 3);
      settle();
      checks++;
      if (obs_q.size() !== exp_q.size() || done_q.size() !== exp_good_q.size()) begin
        errors++; $display("FAIL filter%0d: got %0d beats %0d dones want %0d %0d", k, obs_q.size(), done_q.size(), exp_q.size(), exp_good_q.size());
      end
    end
    clear_obs();
    send_frame(LMAC, 16'h0800, 8'h45, 8'h11, LIP, LPORT, 16'd9, 1'b0, -1, -1, -1, 1'b0, 3);
    settle();
    checks++;
    if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0] || done_q.size() !== 1 || done_q[0] !== 1'b1) begin
      errors++; $display("FAIL filter_min_len: got %0d beats %h want 1 beat %h good", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 10'h3FF, exp_q[0]);
    end
  endtask

  task automatic test_bcast();
    clear_obs();
    send_frame('1, 16'h0800, 8'h45, 8'h11, LIP, LPORT, 16'd16, 1'b0, -1, -1, -1, 1'b0, 3);
    settle();
    checks++;
    if (obs_q.size() !== 8) begin errors++; $display("FAIL bcast_beats: got %0d want 8", obs_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bcast_beat%0d: want %h", i, exp_q[i]); end
    end
    checks++;
    if (done_q.size() !== 1 || done_q[0] !== 1'b1) begin errors++; $display("FAIL bcast_done: got %0d pulses", done_q.size()); end
    checks++;
    if (b_beats !== 0 || b_dones !== 0) begin
      errors++; $display("FAIL bcast_nobcast: got %0d beats %0d dones want 0 0", b_beats, b_dones);
    end
  endtask

  task automatic test_trunc_er();
    clear_obs();
    send_frame(LMAC, 16'h0800, 8'h45, 8'h11, LIP, LPORT, 16'd16, 1'b1, 4, -1, -1, 1'b0, 3);
    settle();
    checks++;
    if (obs_q.size() !== 4) begin errors++; $display("FAIL trunc_beats: got %0d want 4", obs_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL trunc_beat%0d: want %h", i, exp_q[i]); end
    end
    checks++;
    if (done_q.size() !== 1 || done_q[0] !== 1'b0) begin errors++; $display("FAIL trunc_done: got %0d pulses want 1 bad", done_q.size()); end
    clear_obs();
    send_frame(LMAC, 16'h0800, 8'h45, 8'h11, LIP, LPORT, 16'd16, 1'b1, -1, 5, -1, 1'b0, 3);
    settle();
    checks++;
    if (obs_q.size() !== 8 || obs_q[7] !== exp_q[7]) begin errors++; $display("FAIL rxer_beats: got %0d want 8 ending %h", obs_q.size(), exp_q[7]); end
    checks++;
    if (done_q.size() !== 1 || done_q[0] !== 1'b0) begin errors++; $display("FAIL rxer_done: got %0d pulses want 1 bad", done_q.size()); end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    send_frame(LMAC, 16'h0800, 8'h45, 8'h11, LIP, LPORT, 16'd40, 1'b0, -1, -1, 3, 1'b0, 2);
    settle();
    checks++;
    if (obs_q.size() !== 3 || done_q.size() !== 0) begin
      errors++; $display("FAIL rstmid_out: got %0d beats %0d dones want 3 0", obs_q.size(), done_q.size());
    end
    checks++;
    if (a_len !== exp_len) begin errors++; $display("FAIL rstmid_len: got %h want %h", a_len, exp_len); end
    clear_obs();
    send_frame(LMAC, 16'h0800, 8'h45, 8'h11, LIP, LPORT, 16'd16, 1'b1, -1, -1, -1, 1'b0, 3);
    settle();
    checks++;
    if (obs_q.size() !== 8 || done_q.size() !== 1 || done_q[0] !== 1'b1) begin
      errors++; $display("FAIL rstmid_next: got %0d beats %0d dones want 8 1", obs_q.size(), done_q.size());
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) begin
      clear_obs();
      for (int n = 0; n < 3; n++) begin
        int v;
        v = $urandom_range(0, 5);
        send_frame(v == 2 ? 48'h085700F4AEE6 : v == 4 ? '1 : LMAC, 16'h0800, 8'h45, v == 5 ? 8'h06 : 8'h11, LIP,
                   v == 3 ? 16'd1537 : LPORT, 16'($urandom_range(9, 80)), 1'b0, -1, -1, -1, 1'b0, 1);
      end
      settle();
      checks++;
      if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b%0d_beats: got %0d want %0d", r, obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        checks++;
        if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b%0d_beat%0d: want %h", r, i, exp_q[i]); end
      end
      checks++;
      if (done_q.size() !== exp_good_q.size()) begin errors++; $display("FAIL b2b%0d_dones: got %0d want %0d", r, done_q.size(), exp_good_q.size()); end
      foreach (exp_good_q[i]) begin
        checks++;
        if (i >= done_q.size() || done_q[i] !== exp_good_q[i]) begin errors++; $display("FAIL b2b%0d_good%0d: want %b", r, i, exp_good_q[i]); end
      end
      checks++;
      if (b_beats !== exp_b_beats || b_dones !== exp_b_dones) begin
        errors++; $display("FAIL b2b%0d_dutb: got %0d/%0d want %0d/%0d", r, b_beats, b_dones, exp_b_beats, exp_b_dones);
      end
    end
  endtask

  task automatic test_fcs();
    clear_obs();
    send_frame(LMAC, 16'h0800, 8'h45, 8'h11, LIP, LPORT, 16'd16, 1'b1, -1, -1, -1, 1'b1, 3);
    settle();
    checks++;
    if (obs_q.size() !== 8) begin errors++; $display("FAIL fcs_beats: got %0d want 8", obs_q.size()); end
    checks++;
    if (done_q.size() !== 1 || done_q[0] !== exp_good_q[0]) begin
      errors++; $display("FAIL fcs_good: got %0d pulses want 1 with good=%b", done_q.size(), exp_good_q[0]);
    end
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_nominal();
    test_filter();
    test_bcast();
    test_trunc_er();
    test_reset_mid();
    test_back_to_back();
    test_fcs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/eth_udp_rx.md
Name: eth_udp_rx

Overview:
- Receive-side counterpart of the eth_mac UDP transmitter: a 1000Base GMII byte-stream receiver.
- Strips preamble/SFD, filters on destination MAC, EtherType, IPv4/UDP, destination IP and destination UDP port.
- Delivers the UDP payload as an AXI4-Stream master (no backpressure) plus a per-frame status pulse.
- Sits between the PHY RX pins (clk = rx_clk, 125 MHz) and the user receive logic.

Parameters:
- ACCEPT_BCAST, 1, 1 = also accept dst MAC FF:FF:FF:FF:FF:FF.
- CHECK_MAC, 1, 0 = skip dst MAC comparison (promiscuous).
- MIN_UDP_LEN, 9, smallest accepted UDP length field (header 8 + at least 1 payload byte).

Ports:
- clk  in  1  GMII receive clock; all logic on posedge.
- resetn  in  1  reset, synchronous, active-low.
- rx_dv  in  1  GMII receive data valid.
- rx_er  in  1  GMII receive error.
- rxd  in  8  GMII receive data.
- local_mac  in  48  station MAC, byte 0 = bits [47:40].
- local_ip  in  32  station IPv4 address.
- local_port  in  16  accepted UDP destination port.
- m_axis_tdata  out  8  payload byte.
- m_axis_tvalid  out  1  payload byte valid; no tready, the sink must always accept.
- m_axis_tlast  out  1  last payload byte per UDP length.
- m_axis_tuser  out  1  first payload byte of the frame.
- payload_len  out  16  UDP length − 8; latched at header end.
- frame_done  out  1  one-cycle pulse at the end of every accepted frame.
- frame_good  out  1  valid with frame_done: 1 = complete and error-free.

Behaviour:
- Reset: all outputs 0, state WAIT_IDLE. Reset mid-frame discards the frame; no frame_done is generated for it.
- States:
  - WAIT_IDLE: go to IDLE on the first sampled rx_dv=0.
  - IDLE:
    - rx_dv=1 & rxd=0x55 -> PREAMBLE.
    - rx_dv=1 & any other byte -> DROP.
  - PREAMBLE:
    - 0x55 stays.
    - 0xD5 -> HEADER, hdr_cnt=0.
    - any other byte -> DROP.
    - rx_dv=0 -> IDLE.
  - HEADER: hdr_cnt counts 0..41 (14 Ethernet + 20 IP + 8 UDP).
    - Required values:
      - bytes 0-5 == local_mac, or broadcast if ACCEPT_BCAST; skipped if CHECK_MAC=0.
      - bytes 12-13 == 0x0800.
      - byte 14 == 0x45 (IHL=5 only).
      - byte 23 == 0x11.
      - bytes 30-33 == local_ip.
      - bytes 36-37 == local_port.
      - bytes 38-39 = UDP length L.
    - Any mismatch -> DROP, silently (no status pulse).
    - At byte 39: L < MIN_UDP_LEN -> DROP. Otherwise latch payload_len = L−8 and set rem = L−8.
    - At byte 41 -> PAYLOAD.
    - rx_dv=0 -> IDLE, silently.
  - PAYLOAD:
    - Each byte is registered to m_axis with exactly 1 cycle latency: byte sampled at edge n appears valid during cycle n+1.
    - tuser=1 on the first payload byte.
    - tlast=1 when rem==1, then -> TAIL.
    - rx_dv=0 before rem reaches 0 (truncated frame): no tlast, -> DONE with bad=1.
  - TAIL: consume padding and FCS; rx_dv=0 -> DONE.
  - DONE: frame_done=1 for one cycle, frame_good=!bad, then -> IDLE.
    - If rx_dv is already 1 in this cycle, that byte is treated as IDLE input in the same cycle.
  - DROP: rx_dv=0 -> IDLE.
- Error flag: rx_er=1 on any byte from SFD to end of frame sets bad. Payload streaming continues regardless.
- Counters/widths: rem is 16 bit and never underflows (loaded ≥1). hdr_cnt is 6 bit.
- Between frames: m_axis_tvalid=0. An inter-frame gap of ≥1 rx_dv=0 cycle is sufficient.

Optional Feature:
- ETH_UDP_RX_FCS_CHECK_EN defined:
  - CRC-32 (reflected, poly 0x04C11DB7, init 0xFFFFFFFF) runs over every byte after SFD up to and including the FCS.
  - At DONE, frame_good additionally requires the register to equal the residue 0xC704DD7B.
  - Payload streaming is unchanged; the sink discards on frame_good=0.
- Not defined: no CRC logic; frame_good depends only on completeness and rx_er.

Test Plan:
1. Nominal frame:
   - Stimulus: 7×0x55, 0xD5; dst 08:57:00:F4:AE:E5; type 0x0800; IP dst C0A8C865; port 1536; L=16; payload 00..07; 10 pad bytes; valid FCS.
   - Response: 8 tvalid beats 00..07, tuser on 00, tlast on 07, first beat 1 cycle after byte sampled; payload_len=8; frame_done with frame_good=1.
2. Filtering:
   - Stimulus: repeat 1 with dst MAC …E6, then with port 1537, then with protocol 0x06.
   - Response: no tvalid and no frame_done for any of them; the next nominal frame is received correctly.
3. Broadcast:
   - Stimulus: dst FF:FF:FF:FF:FF:FF, once with ACCEPT_BCAST=1 and once with ACCEPT_BCAST=0.
   - Response: payload delivered with ACCEPT_BCAST=1; dropped with ACCEPT_BCAST=0.
4. Truncation and rx_er:
   - Stimulus (a): rx_dv drops after payload byte 03.
   - Response (a): beats 00..03, no tlast, frame_done with frame_good=0.
   - Stimulus (b): rx_er pulse on payload byte 05.
   - Response (b): all 8 beats delivered, frame_good=0.
5. Reset mid-frame and back-to-back:
   - Stimulus (a): resetn=0 for 2 cycles during payload, rx_dv held high.
   - Response (a): outputs 0 and nothing emitted until rx_dv low; the following frame is received.
   - Stimulus (b): two frames separated by one idle cycle.
   - Response (b): both received.
6. FCS (with ETH_UDP_RX_FCS_CHECK_EN):
   - Stimulus: flip one FCS bit.
   - Response: payload still streams, frame_good=0.
   - Without the macro, the same frame gives frame_good=1.
